// File: rtl/cpu_mc.sv
// cpu_mc -- parametrised multicycle core.
//
// Fetches 16-bit instructions over a valid-qualified port and runs each one
// through a FETCH / EXEC / MEM / HALT state machine. It supports ALU ops,
// ADDI, loads, stores, BEQ, JMP and a halt that EN_L can resume.
//
// Ports
//   CLK, RESET      clock and synchronous active-high reset
//   EN_L            active-low resume strobe; a falling edge seen in HALT resumes
//   Iin, I_VALID    instruction at PC and its valid qualifier
//   Din, D_VALID    load data and its valid qualifier
//   PC, NextPC      current PC and the value it loads at the next edge
//   DataA, DataB    register-file read ports (SA, and SB or [11:9] for ST/BEQ)
//   DataC           register write data (Din for LD, otherwise DataD)
//   DataD           ALU result; the low AW bits are the LD/ST address
//   MW, MR          store strobe (EXEC of ST) and load request (every MEM cycle)
//   HALTED          high while in HALT
module cpu_mc #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          EN_L,
  input  logic [15:0]   Iin,
  input  logic          I_VALID,
  input  logic [DW-1:0] Din,
  input  logic          D_VALID,
  output logic [AW-1:0] PC,
  output logic [AW-1:0] NextPC,
  output logic [DW-1:0] DataA,
  output logic [DW-1:0] DataB,
  output logic [DW-1:0] DataC,
  output logic [DW-1:0] DataD,
  output logic          MW,
  output logic          MR,
  output logic          HALTED
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_e;

  localparam logic [3:0] OP_ALU  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_HLT  = 4'h7;

  // State registers
  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   ir_q, ir_d;
  logic          en_prev_q, en_prev_d;
  logic          mw_q, mw_d;
  logic          mr_q, mr_d;
  logic          halted_q, halted_d;
  logic [DW-1:0] regs_q [8];

  // Register-file write request
  logic          rf_we;
  logic [2:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;

  // Instruction fields
  logic [3:0]        op;
  logic [2:0]        dr, sa, sb_fld, fs, rb_sel;
  logic signed [5:0] imm_s;
  assign op     = ir_q[15:12];
  assign dr     = ir_q[11:9];
  assign sa     = ir_q[8:6];
  assign sb_fld = ir_q[5:3];
  assign fs     = ir_q[2:0];
  assign imm_s  = $signed(ir_q[5:0]);

  // ST sends R[[11:9]] out as store data, and BEQ compares it against R[SA].
  assign rb_sel = (op == OP_ST || op == OP_BEQ) ? dr : sb_fld;

  logic [DW-1:0] data_a, data_b, imm_dw, alu_res, data_d;
  logic [AW-1:0] pc_plus2, br_off, br_tgt, jmp_tgt;
  logic          resume_edge;

  assign data_a = regs_q[sa];
  assign data_b = regs_q[rb_sel];

  // Signed size casts sign-extend (or truncate) imm6 to the target width.
  assign imm_dw   = DW'(imm_s);
  assign br_off   = AW'(imm_s) << 1;
  assign pc_plus2 = pc_q + AW'(2);
  assign br_tgt   = pc_plus2 + br_off;
  // Unsigned cast: truncates when DW > AW, zero-extends when DW < AW.
  assign jmp_tgt  = AW'(data_a);

  // Resume is only counted while already in HALT; en_prev_q is held at 1
  // through reset so an EN_L that is low from power-up is not an edge.
  assign resume_edge = (state_q == S_HALT) && en_prev_q && !EN_L;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    alu_res = '0;
    case (fs)
      3'b000:  alu_res = data_a + data_b;
      3'b001:  alu_res = data_a - data_b;
      3'b010:  alu_res = data_a & data_b;
      3'b011:  alu_res = data_a | data_b;
      3'b100:  alu_res = data_a ^ data_b;
      3'b101:  alu_res = data_a << 1;
      3'b110:  alu_res = data_a >> 1;
      default: alu_res = data_b;
    endcase
  end

  assign data_d = (op == OP_ALU) ? alu_res : (data_a + imm_dw);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    en_prev_d = EN_L;
    rf_we     = 1'b0;
    rf_waddr  = dr;
    rf_wdata  = data_d;

    case (state_q)
      S_FETCH: begin
        if (I_VALID) begin
          ir_d    = Iin;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          OP_ALU, OP_ADDI: begin
            rf_we = 1'b1;
            pc_d  = pc_plus2;
          end
          OP_LD:   state_d = S_MEM;
          OP_BEQ:  pc_d    = (data_a == data_b) ? br_tgt : pc_plus2;
          OP_JMP:  pc_d    = jmp_tgt;
          OP_HLT:  state_d = S_HALT;
          default: pc_d    = pc_plus2;  // ST and every unused opcode
        endcase
      end
      S_MEM: begin
        if (D_VALID) begin
          rf_we    = 1'b1;
          rf_wdata = Din;
          pc_d     = pc_plus2;
          state_d  = S_FETCH;
        end
      end
      default: begin  // S_HALT
        if (resume_edge) begin
          pc_d    = pc_plus2;
          state_d = S_FETCH;
        end
      end
    endcase

    // R0 is hard-wired to zero, so its writes are dropped here.
    if (rf_waddr == 3'd0) rf_we = 1'b0;

    // Strobes are registered from the upcoming state so they line up with it.
    mw_d     = (state_d == S_EXEC) && (ir_d[15:12] == OP_ST);
    mr_d     = (state_d == S_MEM);
    halted_d = (state_d == S_HALT);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      en_prev_q <= 1'b1;
      mw_q      <= 1'b0;
      mr_q      <= 1'b0;
      halted_q  <= 1'b0;
      // NOTE: the register file is small and must read zero after reset, so
      // it is reset here; a large RAM would normally be left unreset.
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      en_prev_q <= en_prev_d;
      mw_q      <= mw_d;
      mr_q      <= mr_d;
      halted_q  <= halted_d;
      if (rf_we) regs_q[rf_waddr] <= rf_wdata;
    end
  end

  assign PC     = pc_q;
  assign NextPC = pc_d;
  assign DataA  = data_a;
  assign DataB  = data_b;
  assign DataD  = data_d;
  assign DataC  = (op == OP_LD) ? Din : data_d;
  assign MW     = mw_q;
  assign MR     = mr_q;
  assign HALTED = halted_q;

endmodule
